// File: rtl/priority_select_rr.sv
`default_nettype none
// ============================================================================
// Module      : priority_select_rr
// Description : Multi-grant priority selector. Picks up to NUM_GRANTS set
//               bits of a WIDTH-bit request vector, either in fixed LSB-first
//               order or round-robin order starting at rr_ptr. The result is
//               registered behind a valid/ready handshake (latency 1).
//               Optional feature macro: PRIORITY_SELECT_MSB_EN adds
//               msb_valid / msb_idx outputs (highest set request bit).
// Revision    : 1.0 - initial release
// ============================================================================
module priority_select_rr #(
    parameter  int WIDTH      = 64,
    parameter  int NUM_GRANTS = 2,
    localparam int IDX_W      = $clog2(WIDTH),
    localparam int CNT_W      = $clog2(NUM_GRANTS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            req,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_GRANTS-1:0]       grant_valid,
    output logic [NUM_GRANTS*IDX_W-1:0] grant_idx,
    output logic [WIDTH-1:0]            grant_mask,
    output logic [CNT_W-1:0]            grant_count,
    output logic [IDX_W-1:0]            rr_ptr
`ifdef PRIORITY_SELECT_MSB_EN
    ,
    output logic                        msb_valid,
    output logic [IDX_W-1:0]            msb_idx
`endif
);

    localparam logic [IDX_W:0]   C_WIDTH_EXT  = (IDX_W + 1)'(WIDTH);
    localparam logic [CNT_W-1:0] C_NUM_GRANTS = CNT_W'(NUM_GRANTS);

    // (base + off) mod WIDTH; base < WIDTH and off <= WIDTH, so one
    // conditional subtract suffices and non-power-of-two WIDTH wraps correctly.
    function automatic logic [IDX_W-1:0] f_wrap_add(input logic [IDX_W-1:0] base,
                                                    input logic [IDX_W:0]   off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= C_WIDTH_EXT) begin
            sum = sum - C_WIDTH_EXT;
        end
        return sum[IDX_W-1:0];
    endfunction

    logic                        r_out_valid;
    logic [NUM_GRANTS-1:0]       r_grant_valid;
    logic [NUM_GRANTS*IDX_W-1:0] r_grant_idx;
    logic [WIDTH-1:0]            r_grant_mask;
    logic [CNT_W-1:0]            r_grant_count;
    logic [IDX_W-1:0]            r_rr_ptr;

    logic                        w_accept;
    logic [IDX_W-1:0]            w_start;
    logic [IDX_W-1:0]            w_scan_idx;
    logic [IDX_W-1:0]            w_last_idx;
    logic [CNT_W-1:0]            w_cnt;
    logic [NUM_GRANTS-1:0]       w_grant_valid;
    logic [NUM_GRANTS*IDX_W-1:0] w_grant_idx;
    logic [WIDTH-1:0]            w_grant_mask;

    assign in_ready = !flush && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_start  = mode ? r_rr_ptr : '0;

    // Walk the request vector in search order and fill grant slots in turn.
    always_comb begin
        w_cnt         = '0;
        w_last_idx    = '0;
        w_scan_idx    = '0;
        w_grant_valid = '0;
        w_grant_idx   = '0;
        w_grant_mask  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_scan_idx = f_wrap_add(w_start, (IDX_W + 1)'(i));
            if (req[w_scan_idx] && (w_cnt < C_NUM_GRANTS)) begin
                for (int k = 0; k < NUM_GRANTS; k++) begin
                    if (w_cnt == CNT_W'(k)) begin
                        w_grant_valid[k]               = 1'b1;
                        w_grant_idx[k*IDX_W +: IDX_W] = w_scan_idx;
                    end
                end
                w_grant_mask[w_scan_idx] = 1'b1;
                w_last_idx               = w_scan_idx;
                w_cnt                    = w_cnt + CNT_W'(1);
            end
        end
    end

    // Output register: reset, flush, accept, then drain, in priority order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_grant_valid <= '0;
            r_grant_idx   <= '0;
            r_grant_mask  <= '0;
            r_grant_count <= '0;
            r_rr_ptr      <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_grant_valid <= w_grant_valid;
            r_grant_idx   <= w_grant_idx;
            r_grant_mask  <= w_grant_mask;
            r_grant_count <= w_cnt;
            if (mode && (w_cnt != '0)) begin
                r_rr_ptr <= f_wrap_add(w_last_idx, (IDX_W + 1)'(1));
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign grant_mask  = r_grant_mask;
    assign grant_count = r_grant_count;
    assign rr_ptr      = r_rr_ptr;

`ifdef PRIORITY_SELECT_MSB_EN
    logic             r_msb_valid;
    logic [IDX_W-1:0] r_msb_idx;
    logic [IDX_W-1:0] w_msb_idx;

    // Highest set request bit; ascending scan so the last hit wins.
    always_comb begin
        w_msb_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i]) begin
                w_msb_idx = IDX_W'(i);
            end
        end
    end

    // MSB result is captured together with the grants.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_msb_valid <= 1'b0;
            r_msb_idx   <= '0;
        end else if (w_accept) begin
            r_msb_valid <= |req;
            r_msb_idx   <= w_msb_idx;
        end
    end

    assign msb_valid = r_msb_valid;
    assign msb_idx   = r_msb_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_priority_select_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_select_rr
// Description : Self-checking bench for priority_select_rr (WIDTH=8,
//               NUM_GRANTS=2): directed scenarios followed by random traffic,
//               all compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_select_rr;

    localparam int C_W  = 8;
    localparam int C_NG = 2;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] req;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] grant_valid;
    logic [5:0] grant_idx;
    logic [7:0] grant_mask;
    logic [1:0] grant_count;
    logic [2:0] rr_ptr;
`ifdef PRIORITY_SELECT_MSB_EN
    logic       msb_valid;
    logic [2:0] msb_idx;
`endif

    priority_select_rr #(.WIDTH(C_W), .NUM_GRANTS(C_NG)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .mode        (mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .req         (req),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_mask  (grant_mask),
        .grant_count (grant_count),
        .rr_ptr      (rr_ptr)
`ifdef PRIORITY_SELECT_MSB_EN
        ,
        .msb_valid   (msb_valid),
        .msb_idx     (msb_idx)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks   = 0;
    int n_failures = 0;

    // Reference model state: what the registered outputs should hold.
    bit       m_valid;
    int       m_rr;
    bit [1:0] m_gv;
    int       m_idx [C_NG];
    bit [7:0] m_mask;
    int       m_cnt;
    bit       m_msb_v;
    int       m_msb_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Result of accepting req: grants are the first set bits met when
    // walking indices start, start+1, ... modulo the width.
    task automatic model_accept(input bit [7:0] rq, input bit md);
        int q[$];
        int start;
        start = md ? m_rr : 0;
        for (int j = 0; j < C_W; j++) begin
            if (rq[(start + j) % C_W]) q.push_back((start + j) % C_W);
        end
        m_gv   = '0;
        m_mask = '0;
        m_cnt  = (q.size() < C_NG) ? q.size() : C_NG;
        for (int k = 0; k < C_NG; k++) begin
            m_idx[k] = 0;
            if (k < q.size()) begin
                m_gv[k]       = 1'b1;
                m_idx[k]      = q[k];
                m_mask[q[k]]  = 1'b1;
            end
        end
        if (md && q.size() > 0) m_rr = (q[m_cnt-1] + 1) % C_W;
        m_msb_v = (rq != 0);
        m_msb_i = 0;
        for (int i = 0; i < C_W; i++) if (rq[i]) m_msb_i = i;
        m_valid = 1'b1;
    endtask

    // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
    task automatic cycle(input bit rn, input bit fl, input bit md, input bit iv,
                         input bit [7:0] rq, input bit ordy);
        bit exp_ready;
        rst_n = rn; flush = fl; mode = md; in_valid = iv; req = rq; out_ready = ordy;
        #1;
        exp_ready = !fl && (!m_valid || ordy);
        if (rn) check("in_ready", in_ready, exp_ready);
        if (!rn) begin
            m_valid = 0; m_rr = 0; m_gv = 0; m_mask = 0; m_cnt = 0;
            m_idx[0] = 0; m_idx[1] = 0; m_msb_v = 0; m_msb_i = 0;
        end else if (fl) begin
            m_valid = 0;
        end else if (iv && exp_ready) begin
            model_accept(rq, md);
        end else if (ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        check("rr_ptr", rr_ptr, m_rr);
        if (m_valid || !rn) begin
            check("grant_valid", grant_valid, m_gv);
            check("grant_idx", grant_idx, {3'(m_idx[1]), 3'(m_idx[0])});
            check("grant_mask", grant_mask, m_mask);
            check("grant_count", grant_count, m_cnt);
`ifdef PRIORITY_SELECT_MSB_EN
            check("msb_valid", msb_valid, m_msb_v);
            check("msb_idx", msb_idx, m_msb_i);
`endif
        end
    endtask

    initial begin
        bit [7:0] r;
        m_valid = 0; m_rr = 0; m_gv = 0; m_mask = 0; m_cnt = 0;
        m_idx[0] = 0; m_idx[1] = 0; m_msb_v = 0; m_msb_i = 0;

        // Reset state
        cycle(0, 0, 0, 0, 8'h00, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_grant_valid", grant_valid, 0);

        // Fixed mode
        cycle(1, 0, 0, 1, 8'b1010_0100, 1);
        check("t1_idx0", grant_idx[2:0], 2);
        check("t1_idx1", grant_idx[5:3], 5);
        check("t1_mask", grant_mask, 8'b0010_0100);
        check("t1_count", grant_count, 2);
        check("t1_rr", rr_ptr, 0);

        // Round-robin streaming
        cycle(1, 0, 1, 1, 8'hFF, 1);
        check("t2a_rr", rr_ptr, 2);
        cycle(1, 0, 1, 1, 8'hFF, 1);
        check("t2b_idx0", grant_idx[2:0], 2);
        check("t2b_idx1", grant_idx[5:3], 3);
        check("t2b_rr", rr_ptr, 4);

        // Wrap-around (first move rr_ptr to 6)
        cycle(1, 0, 1, 1, 8'b0010_0000, 1);
        check("t3_pre_rr", rr_ptr, 6);
        cycle(1, 0, 1, 1, 8'b1000_0001, 1);
        check("t3a_idx0", grant_idx[2:0], 7);
        check("t3a_idx1", grant_idx[5:3], 0);
        check("t3a_rr", rr_ptr, 1);
        cycle(1, 0, 1, 1, 8'b0100_0000, 1);
        check("t3b_gv", grant_valid, 2'b01);
        check("t3b_idx0", grant_idx[2:0], 6);
        check("t3b_rr", rr_ptr, 7);

        // Empty request with rr_ptr=3
        cycle(1, 0, 1, 1, 8'b0000_0101, 1);
        check("t4_pre_rr", rr_ptr, 3);
        cycle(1, 0, 1, 1, 8'h00, 1);
        check("t4_valid", out_valid, 1);
        check("t4_gv", grant_valid, 0);
        check("t4_mask", grant_mask, 0);
        check("t4_rr", rr_ptr, 3);

        // Backpressure then flush
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1, 1, 8'h10, 0);
            check("t5_hold_gv", grant_valid, 2'b00);
            check("t5_hold_rr", rr_ptr, 3);
        end
        cycle(1, 1, 1, 1, 8'h10, 1);
        check("t5_flush_valid", out_valid, 0);
        check("t5_flush_rr", rr_ptr, 3);

        // Reset mid-operation with rr_ptr=5
        cycle(1, 0, 1, 1, 8'h10, 0);
        check("t6_pre_rr", rr_ptr, 5);
        check("t6_pre_valid", out_valid, 1);
        cycle(0, 0, 1, 1, 8'hFF, 0);
        check("t6_valid", out_valid, 0);
        check("t6_rr", rr_ptr, 0);
        check("t6_mask", grant_mask, 0);
        check("t6_count", grant_count, 0);

        cycle(1, 0, 0, 1, 8'b0010_0110, 1);
`ifdef PRIORITY_SELECT_MSB_EN
        check("t6_msb_idx", msb_idx, 5);
        check("t6_msb_valid", msb_valid, 1);
`endif

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) r = 8'h00;
            cycle(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 9) == 0),
                  1'($urandom),
                  ($urandom_range(0, 3) != 0),
                  r,
                  ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
